// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcodes,
// register codes and the fetch state encoding.
package cpu_pkg;

  localparam logic [7:0] OP_ADD     = 8'h00;
  localparam logic [7:0] OP_MUL     = 8'h20;
  localparam logic [7:0] OP_MOV     = 8'h40;
  localparam logic [7:0] OP_NOP     = 8'h70;
  localparam logic [7:0] OP_LD_IMM  = 8'h80;
  localparam logic [7:0] OP_CMP_IMM = 8'h8C;
  localparam logic [7:0] OP_DEC     = 8'h94;
  localparam logic [7:0] OP_INPUT   = 8'h98;
  localparam logic [7:0] OP_OUTPUT  = 8'h9C;
  localparam logic [7:0] OP_BRA     = 8'hA8;
  localparam logic [7:0] OP_BHI     = 8'hB0;
  localparam logic [7:0] OP_BEQ     = 8'hB4;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_IMM,
    ISSUE
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: ROM read port, instruction
// handshake to execute and branch redirect.
interface instruction_fetch_if;
  logic [7:0] address_bus;
  logic [7:0] data_bus;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_imm;
  logic [7:0] instr_pc;
  logic       instr_len2;
  logic       instr_illegal;
  logic       redirect;
  logic [7:0] redirect_pc;

  modport master (
    output address_bus,
    input  data_bus,
    output instr_valid,
    input  instr_ready,
    output instr_opcode,
    output instr_imm,
    output instr_pc,
    output instr_len2,
    output instr_illegal,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  address_bus,
    output data_bus,
    input  instr_valid,
    output instr_ready,
    input  instr_opcode,
    input  instr_imm,
    input  instr_pc,
    input  instr_len2,
    input  instr_illegal,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/instr_length_decoder.sv
// Classifies an opcode as 1 or 2 bytes and flags
// opcodes outside the ISA.
module instr_length_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       len2,
  output logic       illegal
);

  logic legal1;

  // two-byte forms: immediate loads/compares, branches
  always_comb begin
    len2 = 1'b0;
    unique case (1'b1)
      opcode[7:2] == OP_LD_IMM[7:2]:  len2 = 1'b1;
      opcode[7:2] == OP_CMP_IMM[7:2]: len2 = 1'b1;
      opcode == OP_BRA:               len2 = 1'b1;
      opcode == OP_BHI:               len2 = 1'b1;
      opcode == OP_BEQ:               len2 = 1'b1;
      default:                        len2 = 1'b0;
    endcase
  end

  // legal single-byte forms
  always_comb begin
    legal1 = 1'b0;
    unique case (1'b1)
      opcode[7:4] == OP_ADD[7:4]:    legal1 = 1'b1;
      opcode[7:4] == OP_MUL[7:4]:    legal1 = 1'b1;
      opcode[7:4] == OP_MOV[7:4]:    legal1 = 1'b1;
      opcode[7:2] == OP_DEC[7:2]:    legal1 = 1'b1;
      opcode[7:2] == OP_INPUT[7:2]:  legal1 = 1'b1;
      opcode[7:2] == OP_OUTPUT[7:2]: legal1 = 1'b1;
      opcode == OP_NOP:              legal1 = 1'b1;
      default:                       legal1 = 1'b0;
    endcase
  end

  assign illegal = !len2 && !legal1;

endmodule

// File: rtl/instruction_fetch.sv
// Front-end fetch: reads opcode/imm from ROM, issues to execute.
// Optional FETCH_SKIP_NOP_EN drops NOPs inside fetch.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
)(
  input  logic clk,
  input  logic reset,
  instruction_fetch_if.master bus
);

  fetch_state_t state, state_n;
  logic [7:0] pc, pc_n;
  logic [7:0] op, op_n;
  logic [7:0] imm, imm_n;
  logic [7:0] ipc, ipc_n;
  logic       len2, len2_n;
  logic       ill, ill_n;
  logic       dec_len2;
  logic       dec_ill;

  instr_length_decoder u_dec (
    .opcode  (bus.data_bus),
    .len2    (dec_len2),
    .illegal (dec_ill)
  );

  // state and instruction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH_OP;
      pc    <= RESET_PC;
      op    <= 8'h00;
      imm   <= 8'h00;
      ipc   <= 8'h00;
      len2  <= 1'b0;
      ill   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      op    <= op_n;
      imm   <= imm_n;
      ipc   <= ipc_n;
      len2  <= len2_n;
      ill   <= ill_n;
    end
  end

  // next-state; redirect overrides every state
  always_comb begin
    state_n = state;
    pc_n    = pc;
    op_n    = op;
    imm_n   = imm;
    ipc_n   = ipc;
    len2_n  = len2;
    ill_n   = ill;
    if (bus.redirect) begin
      pc_n    = bus.redirect_pc;
      state_n = FETCH_OP;
    end else begin
      unique case (state)
        FETCH_OP: begin
          op_n   = bus.data_bus;
          ipc_n  = pc;
          pc_n   = pc + 8'd1;
          len2_n = dec_len2;
          ill_n  = dec_ill;
          if (dec_len2) begin
            state_n = FETCH_IMM;
`ifdef FETCH_SKIP_NOP_EN
          end else if (bus.data_bus == OP_NOP) begin
            imm_n   = 8'h00;
            state_n = FETCH_OP;
`endif
          end else begin
            imm_n   = 8'h00;
            state_n = ISSUE;
          end
        end
        FETCH_IMM: begin
          imm_n   = bus.data_bus;
          pc_n    = pc + 8'd1;
          state_n = ISSUE;
        end
        ISSUE: begin
          if (bus.instr_ready) state_n = FETCH_OP;
        end
        default: state_n = FETCH_OP;
      endcase
    end
  end

  assign bus.address_bus   = pc;
  assign bus.instr_valid   = (state == ISSUE);
  assign bus.instr_opcode  = op;
  assign bus.instr_imm     = imm;
  assign bus.instr_pc      = ipc;
  assign bus.instr_len2    = len2;
  assign bus.instr_illegal = ill;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a
// queue scoreboard on accepted instructions.
module tb_instruction_fetch;

  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       len2;
    logic       ill;
  } exp_t;

  logic clk;
  logic reset;
  logic [7:0] rom [256];
  exp_t q [$];
  int errors;
  int checks;
  int accept_cnt;
  logic ready_en;
  logic ready_force;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.data_bus = rom[bus.address_bus];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [7:0] op, logic [7:0] imm,
                              logic [7:0] pc, logic len2, logic ill);
    exp_t e;
    e.op = op; e.imm = imm; e.pc = pc; e.len2 = len2; e.ill = ill;
    return e;
  endfunction

  // ready driver: only accept while something is expected
  always @(posedge clk) begin
    #1;
    bus.instr_ready = ready_force || (ready_en && (q.size() > 0));
  end

  // monitor: compare each accepted instruction
  always @(negedge clk) begin
    if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
      exp_t e;
      accept_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got op=%h pc=%h expected none",
                 bus.instr_opcode, bus.instr_pc);
      end else begin
        e = q.pop_front();
        if (bus.instr_opcode !== e.op || bus.instr_imm !== e.imm ||
            bus.instr_pc !== e.pc || bus.instr_len2 !== e.len2 ||
            bus.instr_illegal !== e.ill) begin
          errors++;
          $display("FAIL issue: got op=%h imm=%h pc=%h len2=%b ill=%b expected op=%h imm=%h pc=%h len2=%b ill=%b",
                   bus.instr_opcode, bus.instr_imm, bus.instr_pc,
                   bus.instr_len2, bus.instr_illegal,
                   e.op, e.imm, e.pc, e.len2, e.ill);
        end
      end
    end
  end

  task automatic start_test();
    @(negedge clk); #2;
    reset = 1'b0;
    ready_en = 1'b0;
    ready_force = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    q.delete();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic release_reset();
    @(negedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    while (!bus.instr_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.instr_valid) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got valid=0 expected valid=1", name);
    end
  endtask

  task automatic wait_empty(string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [7:0] h_op, h_imm, h_pc, h_addr;
    int acc0;
    errors = 0;
    checks = 0;
    accept_cnt = 0;
    reset = 1'b0;
    ready_en = 1'b0;
    ready_force = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;

    // T1: 2-byte then 1-byte, ready high
    start_test();
    rom[0] = 8'h82; rom[1] = 8'h00; rom[2] = 8'h98;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_addr", bus.address_bus, 8'h00);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_opcode", bus.instr_opcode, 8'h00);
    chk("rst_imm", bus.instr_imm, 8'h00);
    chk("rst_pc", bus.instr_pc, 8'h00);
    chk("rst_flags", {bus.instr_len2, bus.instr_illegal}, 2'b00);
    q.push_back(mk(8'h82, 8'h00, 8'h00, 1'b1, 1'b0));
    q.push_back(mk(8'h98, 8'h00, 8'h02, 1'b0, 1'b0));
    ready_en = 1'b1;
    release_reset();
    wait_empty("t1");

    // T2: held issue while ready low
    start_test();
    rom[0] = 8'hB4; rom[1] = 8'h0C;
    release_reset();
    wait_valid("t2");
    h_op = bus.instr_opcode;
    h_imm = bus.instr_imm;
    h_pc = bus.instr_pc;
    h_addr = bus.address_bus;
    chk("hold_first", {h_op, h_imm, h_pc, h_addr}, 32'hB40C_0002);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #3;
      chk("hold_valid", bus.instr_valid, 1'b1);
      chk("hold_fields",
          {bus.instr_opcode, bus.instr_imm, bus.instr_pc, bus.address_bus},
          {h_op, h_imm, h_pc, h_addr});
    end
    acc0 = accept_cnt;
    q.push_back(mk(8'hB4, 8'h0C, 8'h00, 1'b1, 1'b0));
    ready_en = 1'b1;
    wait_empty("t2");
    repeat (5) @(posedge clk);
    #3;
    chk("one_accept", accept_cnt - acc0, 1);

    // T3: redirect with ready in ISSUE
    start_test();
    rom[0] = 8'h00; rom[4] = 8'h40;
    release_reset();
    wait_valid("t3");
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h04;
    ready_force = 1'b1;
    bus.instr_ready = 1'b1;
    @(posedge clk); #3;
    chk("redir_valid", bus.instr_valid, 1'b0);
    chk("redir_addr", bus.address_bus, 8'h04);
    @(negedge clk); #2;
    bus.redirect = 1'b0;
    ready_force = 1'b0;
    q.push_back(mk(8'h40, 8'h00, 8'h04, 1'b0, 1'b0));
    ready_en = 1'b1;
    wait_empty("t3");

    // T4: 2-byte instruction wrapping 0xFF -> 0x00
    start_test();
    rom[8'hFF] = 8'hA8; rom[0] = 8'h04;
    release_reset();
    wait_valid("t4");
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'hFF;
    @(negedge clk); #2;
    bus.redirect = 1'b0;
    q.push_back(mk(8'hA8, 8'h04, 8'hFF, 1'b1, 1'b0));
    ready_en = 1'b1;
    wait_empty("t4");
    @(posedge clk); #3;
    chk("wrap_pc", bus.address_bus, 8'h01);

    // T5: illegal opcode then legal
    start_test();
    rom[0] = 8'hC3; rom[1] = 8'h25;
    q.push_back(mk(8'hC3, 8'h00, 8'h00, 1'b0, 1'b1));
    q.push_back(mk(8'h25, 8'h00, 8'h01, 1'b0, 1'b0));
    ready_en = 1'b1;
    release_reset();
    wait_empty("t5");

    // T6: NOP handling
    start_test();
    rom[0] = 8'h70; rom[1] = 8'h70; rom[2] = 8'h9E;
`ifndef FETCH_SKIP_NOP_EN
    q.push_back(mk(8'h70, 8'h00, 8'h00, 1'b0, 1'b0));
    q.push_back(mk(8'h70, 8'h00, 8'h01, 1'b0, 1'b0));
`endif
    q.push_back(mk(8'h9E, 8'h00, 8'h02, 1'b0, 1'b0));
    ready_en = 1'b1;
    release_reset();
    wait_empty("t6");
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch unit of the 8-bit core; the reading side of the program ROM interface. It drives the ROM address, reads opcode and optional second byte, and tracks the PC. It classifies each instruction as 1 or 2 bytes and presents the assembled instruction to execute over a valid/ready handshake. Execute redirects the PC on taken branches.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `address_bus`  out  8  ROM address; always equals PC register
- `data_bus`  in  8  ROM read data, combinational from `address_bus`, sampled same cycle
- `instr_valid`  out  1  assembled instruction available
- `instr_ready`  in  1  execute accepts instruction this cycle
- `instr_opcode`  out  8  first instruction byte
- `instr_imm`  out  8  second byte (immediate/target); 0 for 1-byte instructions
- `instr_pc`  out  8  address of `instr_opcode`
- `instr_len2`  out  1  instruction is 2 bytes
- `instr_illegal`  out  1  opcode not in the ISA
- `redirect`  in  1  load PC from `redirect_pc`, flush fetch
- `redirect_pc`  in  8  new PC

## Operation
- States: FETCH_OP, FETCH_IMM, ISSUE. Reset state FETCH_OP.
- FETCH_OP: latch `data_bus` into opcode reg, `instr_pc`<=PC, PC<=PC+1.
  - Go to FETCH_IMM if 2-byte, else clear imm and go to ISSUE.
- FETCH_IMM: latch `data_bus` into imm, PC<=PC+1, go to ISSUE.
- ISSUE: `instr_valid`=1 and all instr_* fields are stable.
  - `instr_ready`=1: go to FETCH_OP.
  - Else hold with no PC change.
- 2-byte opcodes: 0x80–0x83 (LD_IMM), 0x8C–0x8F (CMP_IMM), 0xA8 (BRA), 0xB0 (BHI), 0xB4 (BEQ).
- Legal 1-byte opcodes:
  - top nibble 0000/0010/0100 (ADD/MUL/MOV);
  - 6-bit prefix 100101/100110/100111 (DEC/INPUT/OUTPUT);
  - 0x70 (NOP).
- Any other opcode issues as a 1-byte instruction with `instr_illegal`=1. Fetch continues.
- PC arithmetic is 8-bit modulo: 0xFF+1=0x00. A 2-byte instruction at 0xFF takes its imm from 0x00.
- `redirect` (any state, priority over everything):
  - PC<=`redirect_pc`, state<=FETCH_OP, held instruction discarded.
  - `redirect` together with `instr_ready` in ISSUE: the instruction is NOT accepted.
- Reset mid-operation: all registers return to reset values immediately (asynchronous).

## Timing
- Reset values:
  - `address_bus`=`RESET_PC`, `instr_valid`=0.
  - `instr_opcode`/`instr_imm`/`instr_pc`=0, `instr_len2`=0, `instr_illegal`=0.
- The first FETCH_OP edge is the first rising `clk` after `reset` deasserts. This allows ROM load during reset.
- Latency from FETCH_OP edge to `instr_valid`: 1 cycle (1-byte), 2 cycles (2-byte).
- Throughput with `instr_ready` tied high: one instruction per 2 cycles (1-byte) or 3 cycles (2-byte).
- After `redirect` at edge N:
  - `instr_valid`=0 from N.
  - `address_bus`=`redirect_pc` from N.
  - Opcode at target is latched at N+1.

## Configuration
- `FETCH_SKIP_NOP_EN` defined: a 0x70 opcode latched in FETCH_OP is consumed in fetch. State stays FETCH_OP, PC advances, nothing is issued. `redirect` still has priority.
- Undefined: NOP is issued like any 1-byte instruction.

## Structure
- Shared `cpu_pkg`: opcode localparams (ADD, MUL, MOV, LD_IMM, CMP_IMM, DEC, INPUT, OUTPUT, BRA, BHI, BEQ, NOP), register codes R0–R3, `fetch_state_t` enum.
- Sub-module `instr_length_decoder`: combinational; 8-bit opcode in, `len2` and `illegal` out. Reused later by the disassembler/trace monitor.

## Test plan
- ROM bytes 0x82,0x00,0x98 with ready high after reset:
  - first issue opcode=0x82, imm=0x00, pc=0, len2=1;
  - next opcode=0x98, pc=2, len2=0.
- `instr_ready` low for 4 cycles while ISSUE holds 0xB4,0x0C: fields and `address_bus` unchanged; one acceptance when ready rises.
- `redirect`=1, `redirect_pc`=0x04 asserted with `instr_ready` in ISSUE: instruction not accepted; next issue has pc=0x04.
- 0xA8 at address 0xFF, 0x04 at 0x00: issue imm=0x04, pc=0xFF; PC afterward=0x01.
- Opcode 0xC3: issued with illegal=1, len2=0; following byte fetched next as an opcode.
- With `FETCH_SKIP_NOP_EN`: bytes 0x70,0x70,0x9E issue only 0x9E, pc=2. Without it: three issues.
